// File: rtl/reg_load_arbiter.sv
// Two-requester round-robin arbiter that loads a shared register through an
// IDLE -> LOAD -> ACK handshake, with saturating completion counter.
module reg_load_arbiter #(
  parameter int width = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [width-1:0] DATA0,
  input  logic             REQ1,
  input  logic [width-1:0] DATA1,
  output logic [width-1:0] DATA_OUT,
  output logic             LOAD,
  output logic             ACK0,
  output logic             ACK1,
  output logic             BUSY,
  output logic             LAST,
  output logic [7:0]       COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [width-1:0] data_q, data_d;
  logic [7:0]       count_q, count_d;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie the requester not served last wins.
          grant_d = (REQ0 && REQ1) ? ~last_q : REQ1;
          data_d  = grant_d ? DATA1 : DATA0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_ACK;
      S_ACK: begin
        state_d = S_IDLE;
        last_d  = grant_q;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Strobes decode purely from registered state so they are glitch-free.
  assign DATA_OUT = data_q;
  assign LOAD     = (state_q == S_LOAD);
  assign ACK0     = (state_q == S_ACK) && !grant_q;
  assign ACK1     = (state_q == S_ACK) &&  grant_q;
  assign BUSY     = (state_q != S_IDLE);
  assign LAST     = last_q;
  assign COUNT    = count_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter: vector table for arbitration order,
// hand sequences for streaming, mid-transaction drop, reset abort and saturation.
module tb_reg_load_arbiter;

  logic       CLK, RST, REQ0, REQ1;
  logic [7:0] DATA0, DATA1, DATA_OUT, COUNT;
  logic       LOAD, ACK0, ACK1, BUSY, LAST;

  reg_load_arbiter #(.width(8)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
    .DATA_OUT(DATA_OUT), .LOAD(LOAD), .ACK0(ACK0), .ACK1(ACK1), .BUSY(BUSY),
    .LAST(LAST), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {logic idx; logic [7:0] data;} exp_t;
  typedef struct {
    logic r0, r1; logic [7:0] d0, d1;
    logic eidx; logic [7:0] edata; logic [7:0] ecnt;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0, n_total = 0;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Scoreboard: every ACK must match the oldest outstanding expected grant.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ACK0 || ACK1) begin
        chk("ack_excl", {31'd0, ACK0 & ACK1}, 0);
        chk("ack_no_load", {31'd0, LOAD}, 0);
        if (sb.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("ack_idx", {31'd0, ACK1}, {31'd0, mon_e.idx});
          chk("ack_data", {24'd0, DATA_OUT}, {24'd0, mon_e.data});
        end
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; DATA0 = 8'h00; DATA1 = 8'h00;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("rst_data", {24'd0, DATA_OUT}, 0);
    chk("rst_load", {31'd0, LOAD}, 0);
    chk("rst_ack",  {30'd0, ACK0, ACK1}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_last", {31'd0, LAST}, 1);
    chk("rst_count", {24'd0, COUNT}, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One isolated transaction: request, LOAD one cycle later, ACK, back to IDLE.
  task automatic do_txn(input vec_t v);
    @(negedge CLK);
    REQ0 = v.r0; REQ1 = v.r1; DATA0 = v.d0; DATA1 = v.d1;
    sb.push_back('{idx: v.eidx, data: v.edata});
    @(negedge CLK);
    chk("txn_load", {31'd0, LOAD}, 1);
    chk("txn_busy", {31'd0, BUSY}, 1);
    chk("txn_load_data", {24'd0, DATA_OUT}, {24'd0, v.edata});
    @(negedge CLK);
    chk("txn_ack_seen", {31'd0, ACK0 | ACK1}, 1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    chk("txn_idle", {31'd0, BUSY}, 0);
    chk("txn_last", {31'd0, LAST}, {31'd0, v.eidx});
    chk("txn_count", {24'd0, COUNT}, {24'd0, v.ecnt});
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // r0 r1 d0 d1 -> granted idx, loaded data, COUNT afterwards
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'd1};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22, 8'd2};
    vecs[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 8'h33, 8'd3};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 8'h5A, 8'd4};
    vecs[4] = '{1'b0, 1'b1, 8'h99, 8'h66, 1'b1, 8'h66, 8'd5};
    vecs[5] = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b0, 8'h77, 8'd6};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'hEE, 1'b0, 8'hFF, 8'd7};
    vecs[7] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 8'h02, 8'd8};

    do_reset();
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    @(negedge CLK);
    chk("idle_holds_data", {24'd0, DATA_OUT}, 8'h02);

    // Both held from reset: requester 0 wins the first tie, then strict alternation.
    do_reset();
    @(negedge CLK);
    REQ0 = 1'b1; REQ1 = 1'b1; DATA0 = 8'h11; DATA1 = 8'h22;
    for (int i = 0; i < 4; i++) sb.push_back('{idx: i[0], data: i[0] ? 8'h22 : 8'h11});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rr_load", {31'd0, LOAD}, 1);
      chk("rr_data", {24'd0, DATA_OUT}, i[0] ? 8'h22 : 8'h11);
      @(negedge CLK);
      chk("rr_ack0", {31'd0, ACK0}, {31'd0, ~i[0]});
      @(negedge CLK);
      chk("rr_idle", {31'd0, BUSY}, 0);
      chk("rr_count", {24'd0, COUNT}, i + 1);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;

    // Requester 1 drops REQ and scrambles DATA during LOAD; transaction completes.
    do_reset();
    @(negedge CLK);
    REQ1 = 1'b1; DATA1 = 8'h5A;
    sb.push_back('{idx: 1'b1, data: 8'h5A});
    @(negedge CLK);
    chk("drop_load", {31'd0, LOAD}, 1);
    REQ1 = 1'b0; DATA1 = 8'hC3;
    @(negedge CLK);
    chk("drop_ack1", {31'd0, ACK1}, 1);
    chk("drop_data", {24'd0, DATA_OUT}, 8'h5A);
    @(negedge CLK);
    chk("drop_count", {24'd0, COUNT}, 1);
    chk("drop_last", {31'd0, LAST}, 1);

    // Reset mid-LOAD aborts immediately, no ACK follows.
    do_reset();
    @(negedge CLK);
    REQ0 = 1'b1; DATA0 = 8'hA5;
    @(negedge CLK);
    chk("abort_load_pre", {31'd0, LOAD}, 1);
    #2 RST = 1'b1;
    #1;
    chk("abort_load", {31'd0, LOAD}, 0);
    chk("abort_busy", {31'd0, BUSY}, 0);
    chk("abort_data", {24'd0, DATA_OUT}, 0);
    chk("abort_count", {24'd0, COUNT}, 0);
    chk("abort_last", {31'd0, LAST}, 1);
    @(negedge CLK);
    RST = 1'b0; REQ0 = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("abort_quiet", {29'd0, LOAD, ACK0, ACK1}, 0);
    end
    do_txn('{1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'd1});

    // 260 back-to-back loads from requester 0: COUNT saturates at 255.
    do_reset();
    @(negedge CLK);
    REQ0 = 1'b1; DATA0 = 8'h3C;
    for (int i = 0; i < 260; i++) begin
      sb.push_back('{idx: 1'b0, data: 8'h3C});
      repeat (3) @(negedge CLK);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i >= 253) chk("sat_count", {24'd0, COUNT}, exp_cnt);
    end
    REQ0 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sat_final", {24'd0, COUNT}, 255);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 SHALL have parameter: width, 1, data width of both requester buses and of the shared register being loaded.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: REQ0  input  1  requester 0 write request; held high until ACK0.
REQ-005 SHALL have port: DATA0  input  width  requester 0 write data; valid while REQ0 high.
REQ-006 SHALL have port: REQ1  input  1  requester 1 write request; held high until ACK1.
REQ-007 SHALL have port: DATA1  input  width  requester 1 write data; valid while REQ1 high.
REQ-008 SHALL have port: DATA_OUT  output  width  data bus to the shared register's DATA_IN.
REQ-009 SHALL have port: LOAD  output  1  one-cycle load strobe (clock enable) for the shared register.
REQ-010 SHALL have port: ACK0  output  1  one-cycle completion pulse to requester 0.
REQ-011 SHALL have port: ACK1  output  1  one-cycle completion pulse to requester 1.
REQ-012 SHALL have port: BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port: LAST  output  1  index of the most recently served requester.
REQ-014 SHALL have port: COUNT  output  8  number of completed loads, saturating.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, LOAD, ACK; all outputs driven from registers or decoded from state only (Moore, glitch-free).
REQ-016 SHALL, in IDLE with REQ0=REQ1=0, remain in IDLE; all strobes low; DATA_OUT holds its last value.
REQ-017 SHALL, in IDLE with exactly one REQn high at a posedge, grant requester n, latch DATAn into DATA_OUT, and move to LOAD.
REQ-018 SHALL, in IDLE with both REQ high, grant the requester not equal to LAST (round-robin); after reset requester 0 wins the first tie.
REQ-019 SHALL assert LOAD for exactly the one cycle the FSM is in LOAD, then move unconditionally to ACK.
REQ-020 SHALL assert ACKn (granted n only) for exactly the one cycle the FSM is in ACK, then move unconditionally to IDLE.
REQ-021 SHALL, on leaving ACK, update LAST to the granted index and increment COUNT by 1, saturating at 255 (no wrap).
REQ-022 SHALL hold DATA_OUT constant from the grant edge through the end of the ACK cycle.
REQ-023 SHALL ignore REQ/DATA changes during LOAD and ACK; a requester dropping REQ mid-transaction does not abort it.
REQ-024 SHALL treat a REQn still high in IDLE after its ACK as a new request (arbitrated normally).
REQ-025 SHALL have latency: REQ sampled at edge k -> LOAD high in cycle k..k+1 -> ACK high in cycle k+1..k+2 -> IDLE at k+2; max throughput one load per 3 cycles.
REQ-026 SHALL never assert ACK0 and ACK1 together, and never assert LOAD outside the LOAD state.

Reset
REQ-027 SHALL, on RST high, immediately (without a clock) force: state IDLE, DATA_OUT 0, LOAD 0, ACK0 0, ACK1 0, BUSY 0, LAST 1, COUNT 0.
REQ-028 SHALL, on RST asserted during LOAD or ACK, abort the transaction: no ACK issued, COUNT and LAST take reset values.
REQ-029 SHALL sample requests again on the first posedge CLK after RST deasserts.

Verification
REQ-030 SHALL cover: width=8, reset, REQ0=1 DATA0=8'hA5 -> LOAD 1 cycle later with DATA_OUT=A5, ACK0 next cycle, COUNT=1, LAST=0.
REQ-031 SHALL cover: REQ0=REQ1=1 held continuously, DATA0=11, DATA1=22 -> loads alternate 11,22,11,22; ACK0/ACK1 alternate every 3 cycles.
REQ-032 SHALL cover: first tie after reset -> requester 0 served first (LAST reset 1).
REQ-033 SHALL cover: REQ1 dropped during LOAD -> ACK1 still issued, DATA_OUT unchanged, COUNT increments.
REQ-034 SHALL cover: RST pulsed mid-LOAD -> LOAD/BUSY fall asynchronously, no ACK, COUNT=0, DATA_OUT=0.
REQ-035 SHALL cover: 260 back-to-back single-requester loads -> COUNT stops at 255.
